// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-select encodings and the queued result entry with its flags.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_NOT = 3'b101;
   localparam logic [2:0] ALU_MUL = 3'b110;
   localparam logic [2:0] ALU_SHL = 3'b111;

   typedef struct packed {
      logic [7:0] data;
      logic [2:0] sel;
      logic       zero;
      logic       ext;
   } alu_entry_t;

   // ext meaning depends on the op: carry, borrow, or overflow out of the low nibble.
   function automatic alu_entry_t make_entry(input logic [7:0] data, input logic [2:0] sel);
      alu_entry_t e;
      e.data = data;
      e.sel  = sel;
      e.zero = (data == 8'h00);
      case (sel)
         ALU_ADD:          e.ext = data[4];
         ALU_SUB:          e.ext = data[7];
         ALU_MUL, ALU_SHL: e.ext = |data[7:4];
         default:          e.ext = 1'b0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is read combinationally from storage.
module alu_sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 13
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign count   = wr_ptr_q - rd_ptr_q;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is deliberately not reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/alu_result_buffer.sv
// Captures ALU results with derived flags, queues them, and drains via valid/ready.
module alu_result_buffer
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             in_data,
   input  logic [2:0]             in_sel,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [7:0]             out_data,
   output logic [2:0]             out_sel,
   output logic                   out_zero,
   output logic                   out_ext,
   output logic [$clog2(DEPTH):0] count,
   output logic [CNT_W-1:0]       done_cnt
);

   localparam int unsigned EW = $bits(alu_entry_t);

   alu_entry_t       wr_entry, head;
   logic [EW-1:0]    head_bits;
   logic             push, pop, full, empty;
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

   assign wr_entry  = make_entry(in_data, in_sel);
   // in_ready is purely registered state, so a full FIFO refuses a push even while popping.
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   alu_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (head_bits),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign head     = alu_entry_t'(head_bits);
   assign out_data = head.data;
   assign out_sel  = head.sel;
   assign out_zero = head.zero;
   assign out_ext  = head.ext;

   always_comb begin
      done_cnt_d = done_cnt_q;
      if (pop) done_cnt_d = done_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) done_cnt_q <= '0;
      else        done_cnt_q <= done_cnt_d;
   end

   assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: queue model compared every cycle plus directed literal checks.
module tb_alu_result_buffer;
   import alu_pkg::*;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic [2:0] in_sel = 3'b000;

   logic        a_in_ready, a_out_valid, a_out_zero, a_out_ext;
   logic [7:0]  a_out_data;
   logic [2:0]  a_out_sel;
   logic [2:0]  a_count;
   logic [15:0] a_done;
   logic        b_in_ready, b_out_valid, b_out_zero, b_out_ext;
   logic [7:0]  b_out_data;
   logic [2:0]  b_out_sel;
   logic [2:0]  b_count;
   logic [3:0]  b_done;

   int n_checks = 0;
   int n_fail = 0;

   logic [7:0]  q_data[$];
   logic [2:0]  q_sel[$];
   int unsigned m_done = 0;
   logic        m_valid, m_push, m_pop;

   always #5 clk = ~clk;

   alu_result_buffer #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_data(in_data), .in_sel(in_sel), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_data(a_out_data), .out_sel(a_out_sel), .out_zero(a_out_zero), .out_ext(a_out_ext),
      .count(a_count), .done_cnt(a_done)
   );

   alu_result_buffer #(.DEPTH(DEPTH), .CNT_W(4)) u_dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_data(in_data), .in_sel(in_sel), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_data(b_out_data), .out_sel(b_out_sel), .out_zero(b_out_zero), .out_ext(b_out_ext),
      .count(b_count), .done_cnt(b_done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic m_ext(input logic [7:0] d, input logic [2:0] s);
      case (s)
         3'd0:       return ((d / 16) % 2) == 1;
         3'd1:       return d >= 8'd128;
         3'd6, 3'd7: return d >= 8'd16;
         default:    return 1'b0;
      endcase
   endfunction

   // Compare on the falling edge, then advance the model by what the next rising edge does.
   always @(negedge clk) begin
      if (!rst_n) begin
         q_data.delete();
         q_sel.delete();
         m_done = 0;
      end else begin
         m_valid = (q_data.size() != 0);
         chk("a_out_valid", a_out_valid, m_valid);
         chk("b_out_valid", b_out_valid, m_valid);
         chk("a_in_ready", a_in_ready, q_data.size() < DEPTH);
         chk("b_in_ready", b_in_ready, q_data.size() < DEPTH);
         chk("a_count", a_count, q_data.size());
         chk("b_count", b_count, q_data.size());
         chk("a_done", a_done, m_done % 65536);
         chk("b_done", b_done, m_done % 16);
         if (m_valid) begin
            chk("a_out_data", a_out_data, q_data[0]);
            chk("a_out_sel", a_out_sel, q_sel[0]);
            chk("a_out_zero", a_out_zero, q_data[0] == 8'd0);
            chk("a_out_ext", a_out_ext, m_ext(q_data[0], q_sel[0]));
            chk("b_out_data", b_out_data, q_data[0]);
            chk("b_out_ext", b_out_ext, m_ext(q_data[0], q_sel[0]));
         end
         m_push = in_valid && (q_data.size() < DEPTH);
         m_pop  = m_valid && out_ready;
         if (m_pop) begin
            void'(q_data.pop_front());
            void'(q_sel.pop_front());
            m_done++;
         end
         if (m_push) begin
            q_data.push_back(in_data);
            q_sel.push_back(in_sel);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset();
      chk("rst_a_count", a_count, 0);
      chk("rst_a_valid", a_out_valid, 0);
      chk("rst_a_ready", a_in_ready, 1);
      chk("rst_a_done", a_done, 0);
      chk("rst_b_done", b_done, 0);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #2;
      chk_reset();
      step();
      rst_n = 1'b1;
   endtask

   logic [7:0] fl_data [5] = '{8'h13, 8'hF3, 8'h00, 8'h31, 8'h0C};
   logic [2:0] fl_sel  [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
   logic       fl_zero [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic       fl_ext  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      #1 rst_n = 1'b0;
      #2 chk_reset();
      step();
      step();
      rst_n = 1'b1;
      step();

      // Flag derivation, four entries fill the queue, fifth follows.
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = fl_data[i];
         in_sel  = fl_sel[i];
         step();
      end
      in_valid = 1'b0;
      chk("flag_fill_count", a_count, 4);
      chk("flag_fill_ready", a_in_ready, 0);
      for (int k = 0; k < 4; k++) begin
         chk("flag_zero", a_out_zero, fl_zero[k]);
         chk("flag_ext", a_out_ext, fl_ext[k]);
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = fl_data[4];
      in_sel   = fl_sel[4];
      step();
      in_valid = 1'b0;
      chk("flag5_data", a_out_data, 8'h0C);
      chk("flag5_zero", a_out_zero, fl_zero[4]);
      chk("flag5_ext", a_out_ext, fl_ext[4]);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Full: push five with no consumer, then release.
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'hA0 + 8'(i);
         in_sel  = 3'(i);
         step();
      end
      in_data = 8'hA4;
      in_sel  = ALU_XOR;
      step();
      chk("full_count", a_count, 4);
      chk("full_ready", a_in_ready, 0);
      out_ready = 1'b1;
      step();
      chk("full_pop_count", a_count, 3);
      chk("full_ready_rise", a_in_ready, 1);
      chk("full_head", a_out_data, 8'hA1);
      step();
      in_valid = 1'b0;
      chk("full_5th_count", a_count, 3);
      for (int i = 0; i < 3; i++) step();
      out_ready = 1'b0;
      chk("full_drained", a_out_valid, 0);

      // Reset mid-stream with three queued entries.
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'h50 + 8'(i);
         step();
      end
      in_valid = 1'b0;
      chk("pre_reset_count", a_count, 3);
      reset_pulse();

      // Streaming with one-cycle latency.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_sel    = ALU_ADD;
      for (int i = 0; i < 20; i++) begin
         in_data = 8'(i);
         step();
         chk("stream_count", a_count, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("stream_done", a_done, 19);
      chk("stream_done_w", b_done, 3);
      chk("stream_last", a_out_data, 19);

      // Back-pressure hold on entry 19 (0x13, add -> ext set).
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_valid", a_out_valid, 1);
         chk("hold_data", a_out_data, 19);
         chk("hold_sel", a_out_sel, ALU_ADD);
         chk("hold_ext", a_out_ext, 1);
         chk("hold_zero", a_out_zero, 0);
         chk("hold_done", a_done, 19);
      end

      // Counter wrap on the narrow instance and pointer wrap.
      reset_pulse();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         in_data = 8'(i * 7 + 1);
         in_sel  = 3'(i % 8);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("wrap_done_w", b_done, 1);
      chk("wrap_done", a_done, 17);
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
